// File: rtl/sram_stream_loader.sv
// Stream-to-SRAM loader: packs four 32-bit words per 128-bit line,
// writes lines from BASE_ADDR upward, then pulses start.
module sram_stream_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_go,
    input  logic [15:0]  line_count,
    input  logic [31:0]  s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic         WriteEnable,
    output logic [15:0]  WriteAddress,
    output logic [127:0] WriteBus,
    output logic         busy,
    output logic         done,
    output logic         start
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_WRITE,
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     word_q, word_d;
    logic [15:0]    line_q, line_d;
    logic [15:0]    count_q, count_d;
    logic [95:0]    buf_q, buf_d;
    logic [15:0]    addr_q, addr_d;
    logic [127:0]   bus_q, bus_d;
    logic           start_q, start_d;
    logic [15:0]    line_nxt;

    assign line_nxt = line_q + 16'd1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            line_q  <= '0;
            count_q <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
            bus_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            line_q  <= line_d;
            count_q <= count_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
            bus_q   <= bus_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        line_d  = line_q;
        count_d = count_q;
        buf_d   = buf_q;
        addr_d  = addr_q;
        bus_d   = bus_q;
        start_d = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (load_go) begin
                    count_d = line_count;
                    line_d  = '0;
                    word_d  = '0;
                    if (line_count == 16'd0) begin
                        state_d = S_DONE;
                        start_d = 1'b1;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (s_valid) begin
                    word_d = word_q + 2'd1;
                    // Words 0..2 are staged; the 4th completes the line
                    // so the output bus only changes when a write begins.
                    unique case (word_q)
                        2'd0: buf_d[95:64] = s_data;
                        2'd1: buf_d[63:32] = s_data;
                        2'd2: buf_d[31:0]  = s_data;
                        2'd3: begin
                            bus_d   = {buf_q, s_data};
                            addr_d  = BASE_ADDR + line_q;
                            state_d = S_WRITE;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                line_d = line_nxt;
                if (line_nxt == count_q) begin
                    state_d = S_DONE;
                    start_d = 1'b1;
                end else begin
                    state_d = S_FILL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign s_ready      = (state_q == S_FILL);
    assign WriteEnable  = (state_q == S_WRITE);
    assign busy         = (state_q == S_FILL) || (state_q == S_WRITE);
    assign done         = (state_q == S_DONE);
    assign start        = start_q;
    assign WriteAddress = addr_q;
    assign WriteBus     = bus_q;

endmodule
